snn_input_loader: RTL

Upstream feeder for the SNN core. Accepts a 98-byte image frame from the UART receiver, unpacks each byte into eight 1-bit pixels, and writes them into the 784×1 input-unit RAM. Once the full frame is written, it pulses `start` to the core and then hands the RAM address port to the core. It latches the classified digit when the core signals `done`.

---
 rtl/snn_input_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/snn_input_loader.sv
// snn_input_loader: unpacks UART image frames into the 784x1 input-unit RAM, then kicks the SNN core.
// Optional inter-byte timeout resync is built when SNN_LOADER_TIMEOUT_EN is defined.
module snn_input_loader #(
    parameter int unsigned NUM_PIX        = 784,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       clr_rx_rdy,
    input  logic [9:0] core_addr,
    input  logic       core_done,
    input  logic [3:0] core_digit,
    output logic [9:0] ram_addr,
    output logic       ram_d,
    output logic       ram_we,
    output logic       start,
    output logic       busy,
    output logic [3:0] digit,
    output logic       digit_vld,
    output logic       frame_err
);
    localparam logic [9:0] LAST_PIX = 10'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        WAIT_BYTE,
        SHIFT,
        START,
        WAIT_CORE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [9:0] pix_cnt;
    logic       timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_BYTE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        clr_rx_rdy = 1'b0;
        ram_we     = 1'b0;
        ram_d      = 1'b0;
        ram_addr   = pix_cnt;
        start      = 1'b0;
        case (state)
            WAIT_BYTE: begin
                // gated by rst_n so the strobe stays low while reset is held
                if (rx_rdy && rst_n) begin
                    clr_rx_rdy = 1'b1;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                ram_we = 1'b1;
                ram_d  = shreg[0];
                if (bit_cnt == 3'd7) begin
                    state_nxt = (pix_cnt == LAST_PIX) ? START : WAIT_BYTE;
                end
            end
            START: begin
                start     = 1'b1;
                ram_addr  = core_addr;
                state_nxt = WAIT_CORE;
            end
            WAIT_CORE: begin
                ram_addr = core_addr;
                if (core_done) begin
                    state_nxt = WAIT_BYTE;
                end
            end
            default: state_nxt = WAIT_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            pix_cnt   <= '0;
            busy      <= 1'b0;
            digit     <= '0;
            digit_vld <= 1'b0;
        end else begin
            digit_vld <= 1'b0;
            case (state)
                WAIT_BYTE: begin
                    if (clr_rx_rdy) begin
                        shreg   <= rx_data;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end else if (timeout) begin
                        pix_cnt <= '0;
                        busy    <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg   <= {1'b0, shreg[7:1]};
                    pix_cnt <= pix_cnt + 10'd1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                START: begin
                    pix_cnt <= '0;
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        digit     <= core_digit;
                        digit_vld <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SNN_LOADER_TIMEOUT_EN
    logic [19:0] gap_cnt;
    logic        gap_run;

    assign gap_run = (state == WAIT_BYTE) && !clr_rx_rdy && (pix_cnt != '0);
    assign timeout = gap_run && (gap_cnt == TIMEOUT_CYCLES - 20'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= timeout;
            if (gap_run && !timeout) begin
                gap_cnt <= gap_cnt + 20'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign frame_err      = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule
